// File: rtl/multicycle_control.sv
// Multicycle control unit for the RV32I-subset datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WBACK and drives the
// datapath selects and strobes from the latched instruction word. It also
// counts retired instructions: one for every cycle in which the PC advances.
// Optional build macro HALT_ON_ILLEGAL_EN: if defined, an illegal opcode parks
// the unit in HALT until reset. If undefined, an illegal opcode retires as a NOP.
module multicycle_control #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic [3:0]       Status,
  output logic             IREn,
  output logic             PCEn,
  output logic             PCSel,
  output logic             EnWri,
  output logic             ALUsrc,
  output logic             WB,
  output logic             MRW,
  output logic [1:0]       IMMXSel,
  output logic [3:0]       ALUCtl,
  output logic [2:0]       State,
  output logic             Halted,
  output logic [CNT_W-1:0] RetCnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WBACK  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [3:0]       waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] retCnt_q;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic       irBit30;
  logic       unusedIrBits;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign irBit30 = ir_q[30];
  assign unusedIrBits = ^{ir_q[31], ir_q[29:15]};

  logic isR, isIAlu, isLoad, isStore, isBranch, isLui, isLegal;

  assign isR      = (opcode == 7'b0110011);
  assign isIAlu   = (opcode == 7'b0010011);
  assign isLoad   = (opcode == 7'b0000011);
  assign isStore  = (opcode == 7'b0100011);
  assign isBranch = (opcode == 7'b1100011);
  assign isLui    = (opcode == 7'b0110111);
  assign isLegal  = isR | isIAlu | isLoad | isStore | isBranch | isLui;

  logic       decAluSrc;
  logic [1:0] decImmSel;
  logic [3:0] decAluCtl;
  logic       branchTaken;

  // Per-instruction operand/immediate/ALU selection, held for EXEC through WBACK
  always_comb begin
    decAluSrc = 1'b0;
    decImmSel = 2'b00;
    decAluCtl = 4'b0000;
    if (isR) begin
      decAluCtl = {irBit30, funct3};
    end else if (isIAlu) begin
      decAluSrc = 1'b1;
      decAluCtl = (funct3 == 3'b101) ? {irBit30, funct3} : {1'b0, funct3};
    end else if (isLoad) begin
      decAluSrc = 1'b1;
    end else if (isStore) begin
      decAluSrc = 1'b1;
      decImmSel = 2'b01;
    end else if (isLui) begin
      decAluSrc = 1'b1;
      decImmSel = 2'b11;
    end else if (isBranch) begin
      decImmSel = 2'b10;
      decAluCtl = 4'b1000;
    end
  end

  // Branch condition from the ALU flags {N,Z,C,V} of the compare in EXEC
  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      3'b000:  branchTaken = Status[2];
      3'b001:  branchTaken = ~Status[2];
      3'b100:  branchTaken = Status[3] ^ Status[0];
      3'b101:  branchTaken = ~(Status[3] ^ Status[0]);
      3'b110:  branchTaken = ~Status[1];
      3'b111:  branchTaken = Status[1];
      default: branchTaken = 1'b0;
    endcase
  end

  // Next-state sequencing and the datapath control outputs for the current state
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    waitCnt_d = waitCnt_q;
    IREn      = 1'b0;
    PCEn      = 1'b0;
    PCSel     = 1'b0;
    EnWri     = 1'b0;
    ALUsrc    = 1'b0;
    WB        = 1'b1;
    MRW       = 1'b0;
    IMMXSel   = 2'b00;
    ALUCtl    = 4'b0000;
    case (state_q)
      S_FETCH: begin
        IREn    = 1'b1;
        ir_d    = Instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (isLegal) begin
          state_d = S_EXEC;
        end else begin
`ifdef HALT_ON_ILLEGAL_EN
          state_d = S_HALT;
`else
          PCEn    = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        ALUsrc  = decAluSrc;
        IMMXSel = decImmSel;
        ALUCtl  = decAluCtl;
        if (isBranch) begin
          PCEn    = 1'b1;
          PCSel   = branchTaken;
          state_d = S_FETCH;
        end else if (isLoad || isStore) begin
          waitCnt_d = 4'(MEM_WAIT);
          state_d   = S_MEM;
        end else begin
          state_d = S_WBACK;
        end
      end
      S_MEM: begin
        ALUsrc  = decAluSrc;
        IMMXSel = decImmSel;
        ALUCtl  = decAluCtl;
        MRW     = isStore;
        WB      = ~isLoad;
        if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end else if (isStore) begin
          PCEn    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WBACK;
        end
      end
      S_WBACK: begin
        ALUsrc  = decAluSrc;
        IMMXSel = decImmSel;
        ALUCtl  = decAluCtl;
        EnWri   = (rd != 5'd0);
        WB      = ~isLoad;
        PCEn    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
`ifdef HALT_ON_ILLEGAL_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, instruction register, MEM wait counter and retired-instruction counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'd0;
      waitCnt_q <= 4'd0;
      retCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      waitCnt_q <= waitCnt_d;
      if (PCEn) begin
        retCnt_q <= retCnt_q + CNT_W'(1);
      end
    end
  end

  assign State  = state_q;
  assign RetCnt = retCnt_q;

`ifdef HALT_ON_ILLEGAL_EN
  assign Halted = (state_q == S_HALT);
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control.
// Two instances: dut0 with MEM_WAIT=0 and dut2 with MEM_WAIT=2.
// The stimulus pushes one hand-computed expected output vector per checked cycle.
// A negedge monitor pops each expected vector and compares it against the DUT outputs.
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0]  st;
    logic        iren;
    logic        pcen;
    logic        pcsel;
    logic        enWri;
    logic        aluSrc;
    logic        wb;
    logic        mrw;
    logic [1:0]  imm;
    logic [3:0]  ctl;
    logic        halted;
    logic [15:0] ret;
  } exp_t;

  localparam logic [31:0] INS_ADD  = 32'h002081B3;
  localparam logic [31:0] INS_SUB0 = 32'h40208033;
  localparam logic [31:0] INS_SRAI = 32'h4030D213;
  localparam logic [31:0] INS_ADDI = 32'h40008313;
  localparam logic [31:0] INS_LUI  = 32'h123453B7;
  localparam logic [31:0] INS_SW   = 32'h0050A623;
  localparam logic [31:0] INS_BEQ  = 32'h00208463;
  localparam logic [31:0] INS_BLT  = 32'h0020C463;
  localparam logic [31:0] INS_LW   = 32'h0080A283;
  localparam logic [31:0] INS_ILL  = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0 = 1'b1, reset2 = 1'b1;
  logic [31:0] instr0 = 32'd0, instr2 = 32'd0;
  logic [3:0]  status0 = 4'd0, status2 = 4'd0;

  logic        iren0, pcen0, pcsel0, enWri0, aluSrc0, wb0, mrw0, halted0;
  logic [1:0]  imm0;
  logic [3:0]  ctl0;
  logic [2:0]  state0;
  logic [15:0] ret0;

  logic        iren2, pcen2, pcsel2, enWri2, aluSrc2, wb2, mrw2, halted2;
  logic [1:0]  imm2;
  logic [3:0]  ctl2;
  logic [2:0]  state2;
  logic [15:0] ret2;

  multicycle_control #(.MEM_WAIT(0), .CNT_W(16)) dut0 (
    .Clock(clk), .Reset(reset0), .Instr(instr0), .Status(status0),
    .IREn(iren0), .PCEn(pcen0), .PCSel(pcsel0), .EnWri(enWri0),
    .ALUsrc(aluSrc0), .WB(wb0), .MRW(mrw0), .IMMXSel(imm0),
    .ALUCtl(ctl0), .State(state0), .Halted(halted0), .RetCnt(ret0)
  );

  multicycle_control #(.MEM_WAIT(2), .CNT_W(16)) dut2 (
    .Clock(clk), .Reset(reset2), .Instr(instr2), .Status(status2),
    .IREn(iren2), .PCEn(pcen2), .PCSel(pcsel2), .EnWri(enWri2),
    .ALUsrc(aluSrc2), .WB(wb2), .MRW(mrw2), .IMMXSel(imm2),
    .ALUCtl(ctl2), .State(state2), .Halted(halted2), .RetCnt(ret2)
  );

  exp_t  expQ0[$];
  exp_t  expQ2[$];
  string nameQ0[$];
  string nameQ2[$];
  int    checks = 0;
  int    failures = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic iren, input logic pcen,
                              input logic pcsel, input logic enWri, input logic aluSrc,
                              input logic wb, input logic mrw, input logic [1:0] imm,
                              input logic [3:0] ctl, input logic halted, input logic [15:0] ret);
    exp_t e;
    e = {st, iren, pcen, pcsel, enWri, aluSrc, wb, mrw, imm, ctl, halted, ret};
    return e;
  endfunction

  function automatic exp_t fetchE(input logic [15:0] ret);
    return mk(3'd0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0000, 0, ret);
  endfunction

  function automatic exp_t decodeE(input logic [15:0] ret, input logic pcen);
    return mk(3'd1, 0, pcen, 0, 0, 0, 1, 0, 2'b00, 4'b0000, 0, ret);
  endfunction

  function automatic exp_t execE(input logic [15:0] ret, input logic aluSrc, input logic [1:0] imm,
                                 input logic [3:0] ctl, input logic pcen, input logic pcsel);
    return mk(3'd2, 0, pcen, pcsel, 0, aluSrc, 1, 0, imm, ctl, 0, ret);
  endfunction

  function automatic exp_t memE(input logic [15:0] ret, input logic pcen, input logic mrw,
                                input logic wb, input logic aluSrc, input logic [1:0] imm);
    return mk(3'd3, 0, pcen, 0, 0, aluSrc, wb, mrw, imm, 4'b0000, 0, ret);
  endfunction

  function automatic exp_t wbE(input logic [15:0] ret, input logic enWri, input logic wb,
                               input logic aluSrc, input logic [1:0] imm, input logic [3:0] ctl);
    return mk(3'd4, 0, 1, 0, enWri, aluSrc, wb, 0, imm, ctl, 0, ret);
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue its expected outputs
  task automatic applyStimulus(input int which, input logic [31:0] ins, input logic [3:0] st,
                               input logic rst, input logic doCheck, input exp_t e,
                               input string name);
    @(posedge clk);
    #1;
    if (which == 0) begin
      instr0 = ins;
      status0 = st;
      reset0 = rst;
      if (doCheck) begin
        expQ0.push_back(e);
        nameQ0.push_back(name);
      end
    end else begin
      instr2 = ins;
      status2 = st;
      reset2 = rst;
      if (doCheck) begin
        expQ2.push_back(e);
        nameQ2.push_back(name);
      end
    end
  endtask

  task automatic cyc0(input logic [31:0] ins, input logic [3:0] st, input exp_t e, input string name);
    applyStimulus(0, ins, st, 1'b0, 1'b1, e, name);
  endtask

  task automatic cyc2(input logic [31:0] ins, input exp_t e, input string name);
    applyStimulus(2, ins, 4'd0, 1'b0, 1'b1, e, name);
  endtask

  task automatic checkOutput(input exp_t act, input exp_t e, input string name);
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, e);
    end
  endtask

  // Monitor: compare each queued expectation against the DUT outputs mid-cycle
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string n;
    if (expQ0.size() > 0) begin
      e = expQ0.pop_front();
      n = nameQ0.pop_front();
      a = {state0, iren0, pcen0, pcsel0, enWri0, aluSrc0, wb0, mrw0, imm0, ctl0, halted0, ret0};
      checkOutput(a, e, n);
    end
    if (expQ2.size() > 0) begin
      e = expQ2.pop_front();
      n = nameQ2.pop_front();
      a = {state2, iren2, pcen2, pcsel2, enWri2, aluSrc2, wb2, mrw2, imm2, ctl2, halted2, ret2};
      checkOutput(a, e, n);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, INS_ADD, 4'd0, 1'b1, 1'b0, '0, "");
    applyStimulus(0, INS_ADD, 4'd0, 1'b1, 1'b0, '0, "");

    cyc0(INS_ADD, 4'd0, fetchE(0), "add_fetch_after_reset");
    cyc0(INS_ADD, 4'd0, decodeE(0, 0), "add_decode");
    cyc0(INS_ADD, 4'd0, execE(0, 0, 2'b00, 4'b0000, 0, 0), "add_exec");
    cyc0(INS_ADD, 4'd0, wbE(0, 1, 1, 0, 2'b00, 4'b0000), "add_wback");

    cyc0(INS_SUB0, 4'd0, fetchE(1), "sub_fetch");
    cyc0(INS_SUB0, 4'd0, decodeE(1, 0), "sub_decode");
    cyc0(INS_SUB0, 4'd0, execE(1, 0, 2'b00, 4'b1000, 0, 0), "sub_exec");
    cyc0(INS_SUB0, 4'd0, wbE(1, 0, 1, 0, 2'b00, 4'b1000), "sub_x0_wback");

    cyc0(INS_SRAI, 4'd0, fetchE(2), "srai_fetch");
    cyc0(INS_SRAI, 4'd0, decodeE(2, 0), "srai_decode");
    cyc0(INS_SRAI, 4'd0, execE(2, 1, 2'b00, 4'b1101, 0, 0), "srai_exec");
    cyc0(INS_SRAI, 4'd0, wbE(2, 1, 1, 1, 2'b00, 4'b1101), "srai_wback");

    cyc0(INS_ADDI, 4'd0, fetchE(3), "addi_fetch");
    cyc0(INS_ADDI, 4'd0, decodeE(3, 0), "addi_decode");
    cyc0(INS_ADDI, 4'd0, execE(3, 1, 2'b00, 4'b0000, 0, 0), "addi_bit30_exec");
    cyc0(INS_ADDI, 4'd0, wbE(3, 1, 1, 1, 2'b00, 4'b0000), "addi_wback");

    cyc0(INS_LUI, 4'd0, fetchE(4), "lui_fetch");
    cyc0(INS_LUI, 4'd0, decodeE(4, 0), "lui_decode");
    cyc0(INS_LUI, 4'd0, execE(4, 1, 2'b11, 4'b0000, 0, 0), "lui_exec");
    cyc0(INS_LUI, 4'd0, wbE(4, 1, 1, 1, 2'b11, 4'b0000), "lui_wback");

    cyc0(INS_SW, 4'd0, fetchE(5), "sw_fetch");
    cyc0(INS_SW, 4'd0, decodeE(5, 0), "sw_decode");
    cyc0(INS_SW, 4'd0, execE(5, 1, 2'b01, 4'b0000, 0, 0), "sw_exec");
    cyc0(INS_SW, 4'd0, memE(5, 1, 1, 1, 1, 2'b01), "sw_mem");

    cyc0(INS_BEQ, 4'd0, fetchE(6), "beq_t_fetch");
    cyc0(INS_BEQ, 4'd0, decodeE(6, 0), "beq_t_decode");
    cyc0(INS_BEQ, 4'b0100, execE(6, 0, 2'b10, 4'b1000, 1, 1), "beq_taken_exec");

    cyc0(INS_BEQ, 4'd0, fetchE(7), "beq_nt_fetch");
    cyc0(INS_BEQ, 4'd0, decodeE(7, 0), "beq_nt_decode");
    cyc0(INS_BEQ, 4'b0000, execE(7, 0, 2'b10, 4'b1000, 1, 0), "beq_not_taken_exec");

    cyc0(INS_BLT, 4'd0, fetchE(8), "blt_fetch");
    cyc0(INS_BLT, 4'd0, decodeE(8, 0), "blt_decode");
    cyc0(INS_BLT, 4'b1000, execE(8, 0, 2'b10, 4'b1000, 1, 1), "blt_taken_exec");

    cyc0(INS_ILL, 4'd0, fetchE(9), "ill_fetch");
`ifdef HALT_ON_ILLEGAL_EN
    cyc0(INS_ILL, 4'd0, decodeE(9, 0), "ill_decode");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, INS_ILL, 4'd0, (i == 19), 1'b1,
                    mk(3'd5, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0000, 1, 9), "halt_hold");
    end
    cyc0(INS_ADD, 4'd0, fetchE(0), "halt_reset_fetch");
`else
    cyc0(INS_ILL, 4'd0, decodeE(9, 1), "ill_nop_decode");
    cyc0(INS_ADD, 4'd0, fetchE(10), "ill_nop_fetch");
`endif

    cyc2(INS_LW, fetchE(0), "lw_fetch");
    cyc2(INS_LW, decodeE(0, 0), "lw_decode");
    cyc2(INS_LW, execE(0, 1, 2'b00, 4'b0000, 0, 0), "lw_exec");
    for (int i = 0; i < 3; i++) begin
      cyc2(INS_LW, memE(0, 0, 0, 0, 1, 2'b00), "lw_mem_wait");
    end
    cyc2(INS_LW, wbE(0, 1, 0, 1, 2'b00, 4'b0000), "lw_wback");
    cyc2(INS_LW, fetchE(1), "lw2_fetch");
    cyc2(INS_LW, decodeE(1, 0), "lw2_decode");
    cyc2(INS_LW, execE(1, 1, 2'b00, 4'b0000, 0, 0), "lw2_exec");
    applyStimulus(2, INS_LW, 4'd0, 1'b1, 1'b1, memE(1, 0, 0, 0, 1, 2'b00), "lw2_mem_reset_asserted");
    applyStimulus(2, INS_LW, 4'd0, 1'b1, 1'b1, fetchE(0), "reset_hold_fetch");
    applyStimulus(2, INS_LW, 4'd0, 1'b0, 1'b1, fetchE(0), "reset_release_fetch");

    repeat (3) @(posedge clk);
    if (expQ0.size() != 0 || expQ2.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ0.size() + expQ2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control unit that drives the CPU datapath's control inputs (PCSel, EnWri, ALUsrc, WB, MRW, IMMXSel) from the fetched instruction (Instr) and the ALU flags (Status).
- Replaces the bench-driven static control values.
- Sequences each RV32I-subset instruction through FETCH/DECODE/EXEC/MEM/WBACK.
- Issues PC-advance and IR-load strobes and counts retired instructions.

Parameters:
- MEM_WAIT, 0, extra wait cycles in MEM state (MEM lasts 1+MEM_WAIT cycles); range 0..15.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Instr  in  32  instruction word from instruction memory.
- Status  in  4  ALU flags {N,Z,C,V}, bit3=N, bit2=Z, bit1=C, bit0=V.
- IREn  out  1  load instruction register (FETCH only).
- PCEn  out  1  advance PC this cycle.
- PCSel  out  1  1 = branch target, 0 = PC+4.
- EnWri  out  1  register-file write enable.
- ALUsrc  out  1  1 = immediate operand B, 0 = register.
- WB  out  1  writeback source: 1 = ALU, 0 = memory.
- MRW  out  1  data-memory write.
- IMMXSel  out  2  immediate format: 00 I, 01 S, 10 B, 11 U.
- ALUCtl  out  4  ALU operation.
- State  out  3  current state (debug): FETCH 0, DECODE 1, EXEC 2, MEM 3, WBACK 4, HALT 5.
- Halted  out  1  sticky halt flag.
- RetCnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset dominates all other conditions, including mid-instruction. On the next edge:
  - State=FETCH; internal IR=0; wait counter=0; RetCnt=0; Halted=0.
  - Outputs: IREn=1 (FETCH), PCEn=0, PCSel=0, EnWri=0, ALUsrc=0, WB=1, MRW=0, IMMXSel=00, ALUCtl=0000.
- Outputs are functions of State, IR and wait counter only. Exception: PCSel in EXEC also depends on Status (branch condition).
- FETCH: IREn=1; IR<=Instr at edge; -> DECODE.
- DECODE: classify IR[6:0]:
  - 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI -> EXEC.
  - Any other opcode is illegal; see Optional Feature.
- EXEC, MEM, WBACK: ALUsrc, IMMXSel and ALUCtl are held from IR-decode for the whole instruction. In FETCH/DECODE they are 0/00/0000.
  - R: ALUsrc=0, ALUCtl={IR[30],IR[14:12]}.
  - I-ALU: ALUsrc=1, IMMXSel=00, ALUCtl={0,funct3}, except funct3=101 gives {IR[30],101}.
  - LOAD: ALUsrc=1, IMMXSel=00, ALUCtl=0000.
  - STORE: ALUsrc=1, IMMXSel=01, ALUCtl=0000.
  - LUI: ALUsrc=1, IMMXSel=11, ALUCtl=0000.
  - BRANCH: ALUsrc=0, IMMXSel=10, ALUCtl=1000 (subtract).
- EXEC transitions:
  - R/I/LUI -> WBACK.
  - LOAD/STORE -> MEM; wait counter loaded with MEM_WAIT.
  - BRANCH: PCEn=1, PCSel=taken, -> FETCH. Taken conditions by funct3:
    - BEQ(000): Z.
    - BNE(001): !Z.
    - BLT(100): N^V.
    - BGE(101): !(N^V).
    - BLTU(110): !C.
    - BGEU(111): C.
    - Other funct3: not taken.
- MEM: stays while wait counter != 0, decrementing each cycle. Duration is exactly 1+MEM_WAIT cycles.
  - STORE: MRW=1 every MEM cycle. On the last MEM cycle PCEn=1, -> FETCH.
  - LOAD: MRW=0, WB=0. After the last MEM cycle -> WBACK.
- WBACK: EnWri=(IR[11:7]!=0); WB=0 for LOAD, else 1; PCEn=1, PCSel=0; -> FETCH.
- RetCnt increments by 1 on every cycle with PCEn=1; wraps at 2^CNT_W.
- Cycles per instruction: R/I/LUI 4; LOAD 5+MEM_WAIT; STORE 4+MEM_WAIT; BRANCH 3.
- MRW and EnWri are never asserted in the same cycle. EnWri is never asserted outside WBACK.

Optional Feature:
- Macro: HALT_ON_ILLEGAL_EN.
- Defined: illegal opcode in DECODE -> HALT.
  - HALT is absorbing until Reset; Halted=1.
  - All strobes are 0 in HALT; RetCnt frozen.
- Undefined: illegal opcode is a NOP.
  - DECODE asserts PCEn=1, PCSel=0, -> FETCH; RetCnt increments.
  - HALT is unreachable; Halted is tied to 0.

Test Plan:
- Reset held 2 cycles mid-LOAD (in MEM) -> next cycle State=0, IREn=1, MRW=0, EnWri=0, WB=1, IMMXSel=00, RetCnt=0.
- Instr=0x002081B3 (ADD x3,x1,x2):
  - EXEC: ALUsrc=0, ALUCtl=0000.
  - WBACK (cycle 4): EnWri=1, WB=1, PCEn=1.
  - RetCnt=1.
- MEM_WAIT=2, Instr=0x0080A283 (LW x5,8(x1)):
  - IMMXSel=00, ALUsrc=1.
  - MEM lasts 3 cycles with MRW=0, WB=0.
  - WBACK EnWri=1, WB=0; total 7 cycles.
- Instr=0x0050A623 (SW x5,12(x1)), MEM_WAIT=0 -> IMMXSel=01, MRW=1 for exactly 1 cycle with PCEn=1, EnWri never 1, 4 cycles.
- Instr=0x00208463 (BEQ):
  - Status=4'b0100 -> EXEC PCSel=1, PCEn=1.
  - Status=4'b0000 -> PCSel=0, PCEn=1.
  - 3 cycles; IMMXSel=10.
- Instr=0xFFFFFFFF:
  - With HALT_ON_ILLEGAL_EN: State=5, Halted=1, no PCEn for 20 cycles; Reset recovers to FETCH.
  - Without the macro: PCEn=1 in DECODE, RetCnt+1, back to FETCH.
